enemy_controller: RTL
=====================

Name: enemy_controller

Overview:
- Per-enemy sequential controller that sits directly upstream of the enemy sprite renderer.
- Spawns one enemy at a pseudo-random column and type, then moves it down the screen once per frame.
- Absorbs hit pulses from the collision detector and decrements health; on death or escape it waits, then respawns.
- Drives the renderer's type, health, x_mid and y_mid inputs, plus status pulses for the score and lives logic.

Parameters:
- SPAWN_DELAY, 60, frames spent in SPAWN_WAIT before a spawn (1..255).
- DYING_FRAMES, 8, frames spent in DYING after a kill (1..15).
- Y_LIMIT, 472, y_mid at or above which the enemy has escaped.
- LFSR_SEED, 8'hA5, non-zero reset value of the internal LFSR.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  asynchronous active-low reset.
- game_active  in  1  level; low forces IDLE.
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- hit  in  1  one-cycle pulse; a bullet overlapped this enemy.
- enemy_type  out  2  0, 1 or 2 to the renderer.
- enemy_health  out  4  remaining health to the renderer.
- x_mid  out  10  sprite centre column.
- y_mid  out  10  sprite centre row.
- alive  out  1  high only in ACTIVE; the pixel mux gates renderer output with it.
- dying  out  1  high in DYING.
- killed  out  1  one-cycle pulse when health reaches 0.
- escaped  out  1  one-cycle pulse when Y_LIMIT is reached.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, LFSR=LFSR_SEED, all counters 0, enemy_type=0, enemy_health=0, x_mid=320, y_mid=8, all 1-bit outputs 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk cycle in every state, including IDLE.
- States: IDLE, SPAWN_WAIT, ACTIVE, DYING.
- IDLE: when game_active=1, load wait counter with SPAWN_DELAY and go to SPAWN_WAIT.
- SPAWN_WAIT: each frame_tick decrements the wait counter.
  - The tick that brings the counter to 0 performs the spawn on that same clock edge and enters ACTIVE.
  - Spawn type: lfsr[1:0], with value 3 mapped to 0.
  - Spawn health by type: 0→1, 1→2, 2→4.
  - Spawn position: x_mid = 40 + {lfsr[6:0],2'b00} (range 40..548); y_mid = 8.
- ACTIVE, per frame_tick: y_mid += speed, where speed by type is 0→3, 1→2, 2→1.
  - If the new y_mid >= Y_LIMIT: pulse escaped for 1 cycle, reload the wait counter and go to SPAWN_WAIT.
- ACTIVE, on hit:
  - If health > 1: decrement health.
  - If health == 1: set health to 0, pulse killed, load the dying counter with DYING_FRAMES and go to DYING.
- Same-cycle hit and frame_tick in ACTIVE: the hit is evaluated first.
  - If the hit kills, no movement and no escape that cycle.
  - Otherwise both the decrement and the movement apply.
- Hits outside ACTIVE are ignored. At most one decrement per cycle.
- DYING: position, type and health (0) are held. Each frame_tick decrements the dying counter; on reaching 0, reload the wait counter and go to SPAWN_WAIT.
- Output arithmetic: y_mid uses 10-bit unsigned addition; Y_LIMIT <= 1000 guarantees no wrap. x_mid is constant while ACTIVE (see the optional feature for the exception).
- game_active low in any state: go to IDLE next cycle, clear alive and dying, suppress pulses, hold the position outputs.
- Reset mid-operation: immediate return to reset values regardless of state.
- Latency: outputs are registered; a hit is reflected in enemy_health on the following cycle.

Optional Feature:
- Macro: ENEMY_ZIGZAG_EN.
- With the macro defined:
  - In ACTIVE, each frame_tick also moves x_mid by ±2 according to a direction bit.
  - The direction reverses when the next x would be < 16 or > 623; on that frame the enemy reverses and moves 2 in the new direction.
  - The initial direction is lfsr[7] at spawn.
- Without the macro: x_mid is fixed after spawn and the direction register is not built.

Decomposition:
- Shared package enemy_pkg:
  - state encoding;
  - type constants TYPE_SQUARE=0, TYPE_CROSS=1, TYPE_ROUND=2;
  - functions type_health(type) and type_speed(type);
  - screen constants X_SPAWN_BASE=40 and the zigzag bounds 16/623.
- Sub-module enemy_lfsr: seed parameter; ports clk, rst_n, 8-bit output.

Test Plan:
- Reset with LFSR_SEED=8'hA5 and SPAWN_DELAY=2, then game_active=1 with two frame_ticks → ACTIVE on the second tick. Type, health and x_mid must match the spawn mapping applied to the LFSR value on that edge; y_mid=8; alive=1.
- Force type 2 (health 4), then 3 hits → health 4,3,2,1. A 4th hit → health 0, killed high for exactly 1 cycle, dying=1, alive=0; after 8 frame_ticks → SPAWN_WAIT.
- Type 0 from y=8 with frame_ticks only → y_mid increases by 3 per tick. Tick 155 gives y=473 ≥ 472 → escaped pulse, state SPAWN_WAIT.
- Type 0 (health 1), hit and frame_tick in the same cycle → killed pulses, y_mid unchanged, no escaped pulse.
- game_active dropped during ACTIVE → IDLE next cycle, alive=0. Hits while in IDLE or DYING leave health unchanged.
- With ENEMY_ZIGZAG_EN and x_mid=18 moving left → next tick x=16, the following tick x=18 (reversed).

Source files
------------

// File: rtl/enemy_pkg.sv
// enemy_pkg: shared state encoding, enemy type table and screen constants
// for the enemy controller and its helpers.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SPAWN_WAIT = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_DYING      = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_SQUARE = 2'd0;
    localparam logic [1:0] TYPE_CROSS  = 2'd1;
    localparam logic [1:0] TYPE_ROUND  = 2'd2;

    localparam logic [9:0] X_SPAWN_BASE = 10'd40;
    localparam logic [9:0] X_RESET      = 10'd320;
    localparam logic [9:0] Y_SPAWN      = 10'd8;
    localparam logic [9:0] X_ZIG_MIN    = 10'd16;
    localparam logic [9:0] X_ZIG_MAX    = 10'd623;
    localparam logic [9:0] X_ZIG_STEP   = 10'd2;

    // Starting health for each enemy type.
    function automatic logic [3:0] type_health(input logic [1:0] t);
        case (t)
            TYPE_SQUARE: type_health = 4'd1;
            TYPE_CROSS:  type_health = 4'd2;
            default:     type_health = 4'd4;
        endcase
    endfunction

    // Rows moved per frame for each enemy type.
    function automatic logic [9:0] type_speed(input logic [1:0] t);
        case (t)
            TYPE_SQUARE: type_speed = 10'd3;
            TYPE_CROSS:  type_speed = 10'd2;
            default:     type_speed = 10'd1;
        endcase
    endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// enemy_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick
// spawn column, type and zigzag direction. SEED must be non-zero.
module enemy_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    logic feedback;

    // Feedback from taps 8,6,5,4 (bits 7,5,4,3).
    always_comb begin
        feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end

    // Shift every cycle; the sequence never stalls so spawn timing adds entropy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

endmodule

// File: rtl/enemy_controller.sv
// enemy_controller: spawns one enemy, moves it down once per frame, absorbs
// hits, and respawns after death or escape. Outputs feed the sprite renderer
// and the score/lives logic.
// Optional feature: define ENEMY_ZIGZAG_EN to make the enemy drift left/right
// by 2 columns per frame, bouncing between columns 16 and 623.
module enemy_controller
    import enemy_pkg::*;
#(
    parameter int unsigned SPAWN_DELAY  = 60,
    parameter int unsigned DYING_FRAMES = 8,
    parameter int unsigned Y_LIMIT      = 472,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_active,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [1:0] enemy_type,
    output logic [3:0] enemy_health,
    output logic [9:0] x_mid,
    output logic [9:0] y_mid,
    output logic       alive,
    output logic       dying,
    output logic       killed,
    output logic       escaped
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [3:0] dying_cnt;
    logic [7:0] lfsr;

    logic [1:0] spawn_type;
    logic [9:0] spawn_x;
    logic [9:0] y_next;
    logic       hit_kills;

    enemy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    // Spawn attributes and next-row arithmetic derived from current state.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        spawn_type = (lfsr[1:0] == 2'd3) ? TYPE_SQUARE : lfsr[1:0];
        spawn_x    = X_SPAWN_BASE + {1'b0, lfsr[6:0], 2'b00};
        y_next     = y_mid + type_speed(enemy_type);
        hit_kills  = hit && (enemy_health == 4'd1);
    end

`ifdef ENEMY_ZIGZAG_EN
    logic       dir_right;
    logic       dir_next;
    logic [9:0] x_next;

    // Horizontal step; bounce when the next column would leave [16, 623].
    always_comb begin
        dir_next = dir_right;
        x_next   = x_mid;
        if (dir_right) begin
            if (x_mid > X_ZIG_MAX - X_ZIG_STEP) begin
                dir_next = 1'b0;
                x_next   = x_mid - X_ZIG_STEP;
            end else begin
                x_next   = x_mid + X_ZIG_STEP;
            end
        end else begin
            if (x_mid < X_ZIG_MIN + X_ZIG_STEP) begin
                dir_next = 1'b1;
                x_next   = x_mid + X_ZIG_STEP;
            end else begin
                x_next   = x_mid - X_ZIG_STEP;
            end
        end
    end
`else
    // Bit 7 only chooses the zigzag direction, which this build does not have.
    logic lfsr_unused;
    assign lfsr_unused = lfsr[7];
`endif

    // Enemy life-cycle FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= 8'd0;
            dying_cnt    <= 4'd0;
            enemy_type   <= TYPE_SQUARE;
            enemy_health <= 4'd0;
            x_mid        <= X_RESET;
            y_mid        <= Y_SPAWN;
            alive        <= 1'b0;
            dying        <= 1'b0;
            killed       <= 1'b0;
            escaped      <= 1'b0;
`ifdef ENEMY_ZIGZAG_EN
            dir_right    <= 1'b0;
`endif
        end else begin
            killed  <= 1'b0;
            escaped <= 1'b0;
            if (!game_active) begin
                state <= ST_IDLE;
                alive <= 1'b0;
                dying <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        wait_cnt <= 8'(SPAWN_DELAY);
                        state    <= ST_SPAWN_WAIT;
                    end
                    ST_SPAWN_WAIT: begin
                        if (frame_tick) begin
                            wait_cnt <= wait_cnt - 8'd1;
                            if (wait_cnt == 8'd1) begin
                                enemy_type   <= spawn_type;
                                enemy_health <= type_health(spawn_type);
                                x_mid        <= spawn_x;
                                y_mid        <= Y_SPAWN;
                                alive        <= 1'b1;
                                state        <= ST_ACTIVE;
`ifdef ENEMY_ZIGZAG_EN
                                dir_right    <= lfsr[7];
`endif
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (hit_kills) begin
                            // A killing hit pre-empts any movement this cycle.
                            enemy_health <= 4'd0;
                            killed       <= 1'b1;
                            dying_cnt    <= 4'(DYING_FRAMES);
                            alive        <= 1'b0;
                            dying        <= 1'b1;
                            state        <= ST_DYING;
                        end else begin
                            if (hit) begin
                                enemy_health <= enemy_health - 4'd1;
                            end
                            if (frame_tick) begin
                                y_mid <= y_next;
`ifdef ENEMY_ZIGZAG_EN
                                x_mid     <= x_next;
                                dir_right <= dir_next;
`endif
                                if (y_next >= 10'(Y_LIMIT)) begin
                                    escaped  <= 1'b1;
                                    alive    <= 1'b0;
                                    wait_cnt <= 8'(SPAWN_DELAY);
                                    state    <= ST_SPAWN_WAIT;
                                end
                            end
                        end
                    end
                    ST_DYING: begin
                        if (frame_tick) begin
                            dying_cnt <= dying_cnt - 4'd1;
                            if (dying_cnt == 4'd1) begin
                                dying    <= 1'b0;
                                wait_cnt <= 8'(SPAWN_DELAY);
                                state    <= ST_SPAWN_WAIT;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
